// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - hardwired fetch/decode/execute sequencer for the 16-bit teaching CPU.
// Optional memory wait states are enabled with `define CTRL_MEM_WAIT_EN.
module cpu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  ir_op,
    input  logic        zf,
    input  logic        mem_ready,
    output logic        arload,
    output logic        ar_src,
    output logic        pcload,
    output logic        pcinc,
    output logic        irload,
    output logic        drload,
    output logic        acload,
    output logic        acclr,
    output logic [1:0]  alu_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic [3:0]  state,
    output logic [15:0] icount
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH1  = 4'd1,
        ST_FETCH2  = 4'd2,
        ST_DECODE  = 4'd3,
        ST_EX_ADDR = 4'd4,
        ST_EX_RD   = 4'd5,
        ST_EX_ALU  = 4'd6,
        ST_EX_WR   = 4'd7,
        ST_HALT    = 4'd8
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JNZ  = 4'h8;
    localparam logic [3:0] OP_CLA  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op_q;
    logic [15:0] r_icount;
    logic        w_mem_go;

`ifdef CTRL_MEM_WAIT_EN
    assign w_mem_go = mem_ready;
`else
    // Every access completes in one cycle, so the ready input has no effect.
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op_q   <= 4'h0;
            r_icount <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_op_q   <= ir_op;
                r_icount <= r_icount + 16'h0001;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        arload  = 1'b0;
        ar_src  = 1'b0;
        pcload  = 1'b0;
        pcinc   = 1'b0;
        irload  = 1'b0;
        drload  = 1'b0;
        acload  = 1'b0;
        acclr   = 1'b0;
        alu_sel = 2'b00;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next = ST_FETCH1;
            end
            ST_FETCH1: begin
                arload = 1'b1;
                w_next = ST_FETCH2;
            end
            ST_FETCH2: begin
                mem_rd = 1'b1;
                if (w_mem_go) begin
                    irload = 1'b1;
                    pcinc  = 1'b1;
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch decisions use zf only here; the flag is not held afterwards.
                case (ir_op)
                    OP_JMP:  pcload = 1'b1;
                    OP_JZ:   pcload = zf;
                    OP_JNZ:  pcload = ~zf;
                    OP_CLA:  acclr  = 1'b1;
                    default: ;
                endcase
                case (ir_op)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND: w_next = ST_EX_ADDR;
                    OP_HALT: w_next = ST_HALT;
                    default: w_next = ST_FETCH1;
                endcase
            end
            ST_EX_ADDR: begin
                arload = 1'b1;
                ar_src = 1'b1;
                w_next = (r_op_q == OP_STA) ? ST_EX_WR : ST_EX_RD;
            end
            ST_EX_RD: begin
                mem_rd = 1'b1;
                if (w_mem_go) begin
                    drload = 1'b1;
                    w_next = ST_EX_ALU;
                end
            end
            ST_EX_ALU: begin
                acload = 1'b1;
                case (r_op_q)
                    OP_ADD:  alu_sel = 2'b01;
                    OP_SUB:  alu_sel = 2'b10;
                    OP_AND:  alu_sel = 2'b11;
                    default: alu_sel = 2'b00;
                endcase
                w_next = ST_FETCH1;
            end
            ST_EX_WR: begin
                mem_wr = 1'b1;
                if (w_mem_go) w_next = ST_FETCH1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign state  = r_state;
    assign icount = r_icount;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - scoreboard bench for cpu_ctrl: per-cycle expected strobes, state and icount.
// Build with +define+CTRL_MEM_WAIT_EN to add the wait-state sequence.
module tb_cpu_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [3:0]  ir_op;
    logic        zf;
    logic        mem_ready;
    logic        arload;
    logic        ar_src;
    logic        pcload;
    logic        pcinc;
    logic        irload;
    logic        drload;
    logic        acload;
    logic        acclr;
    logic [1:0]  alu_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic        halted;
    logic [3:0]  state;
    logic [15:0] icount;

    cpu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .ir_op     (ir_op),
        .zf        (zf),
        .mem_ready (mem_ready),
        .arload    (arload),
        .ar_src    (ar_src),
        .pcload    (pcload),
        .pcinc     (pcinc),
        .irload    (irload),
        .drload    (drload),
        .acload    (acload),
        .acclr     (acclr),
        .alu_sel   (alu_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .halted    (halted),
        .state     (state),
        .icount    (icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector bit order: arload ar_src pcload pcinc irload drload acload acclr alu_sel[1:0] mem_rd mem_wr halted
    localparam logic [12:0] NONE = 13'h0000;
    localparam logic [12:0] AR   = 13'h1000;
    localparam logic [12:0] ARS  = 13'h0800;
    localparam logic [12:0] PCL  = 13'h0400;
    localparam logic [12:0] PCI  = 13'h0200;
    localparam logic [12:0] IRL  = 13'h0100;
    localparam logic [12:0] DRL  = 13'h0080;
    localparam logic [12:0] ACL  = 13'h0040;
    localparam logic [12:0] ACC  = 13'h0020;
    localparam logic [12:0] A01  = 13'h0008;
    localparam logic [12:0] A10  = 13'h0010;
    localparam logic [12:0] A11  = 13'h0018;
    localparam logic [12:0] MRD  = 13'h0004;
    localparam logic [12:0] MWR  = 13'h0002;
    localparam logic [12:0] HLT  = 13'h0001;
    localparam logic [12:0] F1S  = AR;
    localparam logic [12:0] F2S  = MRD | IRL | PCI;
    localparam logic [12:0] EAS  = AR | ARS;
    localparam logic [12:0] ERS  = MRD | DRL;

    localparam logic [3:0] S_IDLE = 4'd0, S_F1 = 4'd1, S_F2 = 4'd2, S_DEC = 4'd3;
    localparam logic [3:0] S_EA = 4'd4, S_ER = 4'd5, S_EALU = 4'd6, S_EW = 4'd7, S_HALT = 4'd8;

    typedef struct {
        logic [3:0]  st;
        logic [12:0] sb;
        logic [15:0] ic;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Advance to just after the next rising edge and queue what the DUT must show this cycle.
    task automatic cyc(input logic [3:0] st, input logic [12:0] sb, input logic [15:0] ic, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.st = st;
        e.sb = sb;
        e.ic = ic;
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic chk(input bit ok, input string nm);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: state=%0d mem_rd=%b mem_wr=%b irload=%b pcinc=%b halted=%b icount=%h",
                     nm, state, mem_rd, mem_wr, irload, pcinc, halted, icount);
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [12:0] act_sb;
        if (q.size() > 0) begin
            e = q.pop_front();
            act_sb = {arload, ar_src, pcload, pcinc, irload, drload, acload, acclr,
                      alu_sel, mem_rd, mem_wr, halted};
            n_tests++;
            if (state !== e.st || act_sb !== e.sb || icount !== e.ic) begin
                n_fail++;
                $display("FAIL %s: got state=%0d strobes=%h icount=%h, expected state=%0d strobes=%h icount=%h",
                         e.nm, state, act_sb, icount, e.st, e.sb, e.ic);
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; ir_op = 4'h0; zf = 1'b0; mem_ready = 1'b1;
        @(posedge clk);

        cyc(S_IDLE, NONE, 16'd0, "reset");
        chk(state === S_IDLE && icount === 16'd0 && alu_sel === 2'b00 && halted === 1'b0 &&
            arload === 1'b0 && pcload === 1'b0 && pcinc === 1'b0 && irload === 1'b0 &&
            drload === 1'b0 && acload === 1'b0 && acclr === 1'b0 &&
            mem_rd === 1'b0 && mem_wr === 1'b0, "reset_state");
        rst = 1'b0;
        cyc(S_IDLE, NONE, 16'd0, "idle_run");   run = 1'b1;
        // NOP
        cyc(S_F1,  F1S, 16'd0, "nop_f1");       run = 1'b0; ir_op = 4'h0;
        cyc(S_F2,  F2S, 16'd0, "nop_f2");
        cyc(S_DEC, NONE, 16'd0, "nop_dec");
        // ADD 0x012
        cyc(S_F1,  F1S, 16'd1, "add_f1");       ir_op = 4'h3;
        cyc(S_F2,  F2S, 16'd1, "add_f2");
        cyc(S_DEC, NONE, 16'd1, "add_dec");
        cyc(S_EA,  EAS, 16'd2, "add_exaddr");
        cyc(S_ER,  ERS, 16'd2, "add_exrd");
        cyc(S_EALU, ACL | A01, 16'd2, "add_exalu");
        // STA 0x012
        cyc(S_F1,  F1S, 16'd2, "sta_f1");       ir_op = 4'h2;
        cyc(S_F2,  F2S, 16'd2, "sta_f2");
        cyc(S_DEC, NONE, 16'd2, "sta_dec");
        cyc(S_EA,  EAS, 16'd3, "sta_exaddr");
        cyc(S_EW,  MWR, 16'd3, "sta_exwr");
        // JZ taken, zf changes after DECODE
        cyc(S_F1,  F1S, 16'd3, "jz1_f1");       ir_op = 4'h7; zf = 1'b1;
        cyc(S_F2,  F2S, 16'd3, "jz1_f2");
        cyc(S_DEC, PCL, 16'd3, "jz1_dec");
        // JZ not taken
        cyc(S_F1,  F1S, 16'd4, "jz0_f1");       zf = 1'b0;
        cyc(S_F2,  F2S, 16'd4, "jz0_f2");
        cyc(S_DEC, NONE, 16'd4, "jz0_dec");
        // JNZ taken
        cyc(S_F1,  F1S, 16'd5, "jnz_f1");       ir_op = 4'h8;
        cyc(S_F2,  F2S, 16'd5, "jnz_f2");
        cyc(S_DEC, PCL, 16'd5, "jnz_dec");
        // JMP ignores zf
        cyc(S_F1,  F1S, 16'd6, "jmp_f1");       ir_op = 4'h6; zf = 1'b1;
        cyc(S_F2,  F2S, 16'd6, "jmp_f2");
        cyc(S_DEC, PCL, 16'd6, "jmp_dec");
        // CLA
        cyc(S_F1,  F1S, 16'd7, "cla_f1");       ir_op = 4'h9;
        cyc(S_F2,  F2S, 16'd7, "cla_f2");
        cyc(S_DEC, ACC, 16'd7, "cla_dec");
        // LDA
        cyc(S_F1,  F1S, 16'd8, "lda_f1");       ir_op = 4'h1;
        cyc(S_F2,  F2S, 16'd8, "lda_f2");
        cyc(S_DEC, NONE, 16'd8, "lda_dec");
        cyc(S_EA,  EAS, 16'd9, "lda_exaddr");
        cyc(S_ER,  ERS, 16'd9, "lda_exrd");
        cyc(S_EALU, ACL, 16'd9, "lda_exalu");
        // SUB
        cyc(S_F1,  F1S, 16'd9, "sub_f1");       ir_op = 4'h4;
        cyc(S_F2,  F2S, 16'd9, "sub_f2");
        cyc(S_DEC, NONE, 16'd9, "sub_dec");
        cyc(S_EA,  EAS, 16'd10, "sub_exaddr");
        cyc(S_ER,  ERS, 16'd10, "sub_exrd");
        cyc(S_EALU, ACL | A10, 16'd10, "sub_exalu");
        // AND
        cyc(S_F1,  F1S, 16'd10, "and_f1");      ir_op = 4'h5;
        cyc(S_F2,  F2S, 16'd10, "and_f2");
        cyc(S_DEC, NONE, 16'd10, "and_dec");
        cyc(S_EA,  EAS, 16'd11, "and_exaddr");
        cyc(S_ER,  ERS, 16'd11, "and_exrd");
        cyc(S_EALU, ACL | A11, 16'd11, "and_exalu");
        // Undefined opcode behaves as NOP
        cyc(S_F1,  F1S, 16'd11, "opb_f1");      ir_op = 4'hB;
        cyc(S_F2,  F2S, 16'd11, "opb_f2");
        cyc(S_DEC, NONE, 16'd11, "opb_dec");
        // AND aborted by reset in EX_RD
        cyc(S_F1,  F1S, 16'd12, "abort_f1");    ir_op = 4'h5;
        cyc(S_F2,  F2S, 16'd12, "abort_f2");
        cyc(S_DEC, NONE, 16'd12, "abort_dec");
        cyc(S_EA,  EAS, 16'd13, "abort_exaddr");
        cyc(S_ER,  ERS, 16'd13, "abort_exrd");  rst = 1'b1;
        cyc(S_IDLE, NONE, 16'd0, "rst_exrd");
        chk(state === S_IDLE && mem_rd === 1'b0 && drload === 1'b0, "rst_exrd_abort");
        rst = 1'b0;
        // icount wrap from 0xFFFF
        cyc(S_IDLE, NONE, 16'd0, "wrap_idle");  run = 1'b1;
        cyc(S_F1,  F1S, 16'hFFFF, "wrap_f1");   run = 1'b0; ir_op = 4'h0;
        force dut.r_icount = 16'hFFFF;
        cyc(S_F2,  F2S, 16'hFFFF, "wrap_f2");
        release dut.r_icount;
        cyc(S_DEC, NONE, 16'hFFFF, "wrap_dec");
        // HALT holds regardless of run
        cyc(S_F1,  F1S, 16'h0000, "wrap_done"); ir_op = 4'hF;
        cyc(S_F2,  F2S, 16'd0, "halt_f2");
        cyc(S_DEC, NONE, 16'd0, "halt_dec");
        for (int i = 0; i < 10; i++) begin
            cyc(S_HALT, HLT, 16'd1, "halt_hold");
            run = ~run;
        end
        rst = 1'b1; run = 1'b0;
        cyc(S_IDLE, NONE, 16'd0, "rst_halt");   rst = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
        cyc(S_IDLE, NONE, 16'd0, "wait_idle");  run = 1'b1;
        cyc(S_F1,  F1S, 16'd0, "wait_f1");      run = 1'b0; ir_op = 4'h0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(S_F2, MRD, 16'd0, "wait_f2_hold");
        end
        chk(state === S_F2 && mem_rd === 1'b1 && irload === 1'b0 && pcinc === 1'b0, "wait_expired");
        mem_ready = 1'b1;
        cyc(S_F2,  F2S, 16'd0, "wait_f2_go");
        cyc(S_DEC, NONE, 16'd0, "wait_dec");
        chk(state === S_DEC && mem_rd === 1'b0, "wait_decode");
        cyc(S_F1,  F1S, 16'd1, "wait_done");
`endif
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Hardwired control unit for the 16-bit teaching CPU. It sequences fetch, decode and execute by driving the load, increment and memory strobes of the program counter, address register, instruction register, data register and accumulator. It sits between the instruction register's opcode field and the datapath, and is the only driver of `pcload`/`pcinc` in the design.

## Interface
- No parameters; datapath width fixed at 16 bits, opcode width fixed at 4.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  start request; sampled only in IDLE.
- `ir_op`  in  4  opcode field IR[15:12] from the instruction register.
- `zf`  in  1  accumulator-zero flag from the datapath.
- `mem_ready`  in  1  memory access complete; used only when CTRL_MEM_WAIT_EN is defined.
- `arload`  out  1  load AR; source chosen by `ar_src`.
- `ar_src`  out  1  0 = PC, 1 = IR[11:0] zero-extended.
- `pcload`  out  1  load PC from IR[11:0] zero-extended.
- `pcinc`  out  1  PC <= PC+1.
- `irload`  out  1  load IR from memory data.
- `drload`  out  1  load DR from memory data.
- `acload`  out  1  load AC from ALU result.
- `acclr`  out  1  AC <= 0.
- `alu_sel`  out  2  00 pass DR, 01 AC+DR, 10 AC-DR, 11 AC&DR.
- `mem_rd`  out  1  memory read strobe at address AR.
- `mem_wr`  out  1  memory write strobe of AC to address AR.
- `halted`  out  1  high while in HALT.
- `state`  out  4  current state code, for debug.
- `icount`  out  16  instructions decoded since reset.

## Operation
- State codes: IDLE=0, FETCH1=1, FETCH2=2, DECODE=3, EX_ADDR=4, EX_RD=5, EX_ALU=6, EX_WR=7, HALT=8. Codes 9–15 are unreachable; if entered, go to IDLE.
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 JMP, 7 JZ, 8 JNZ, 9 CLA, F HALT. Codes A–E execute as NOP.
- IDLE: all strobes low. Go to FETCH1 if `run`, else stay.
- FETCH1: `arload`=1, `ar_src`=0. Go to FETCH2.
- FETCH2: `mem_rd`=1, `irload`=1, `pcinc`=1. Go to DECODE.
- DECODE: latch `ir_op` into internal `op_q`; increment `icount`, wrapping 0xFFFF->0x0000.
  - JMP: `pcload`=1.
  - JZ: `pcload`=`zf`.
  - JNZ: `pcload`=!`zf`.
  - CLA: `acclr`=1.
  - NOP, JMP, JZ, JNZ, CLA and undefined opcodes go to FETCH1.
  - LDA, STA, ADD, SUB, AND go to EX_ADDR.
  - HALT goes to HALT.
- EX_ADDR: `arload`=1, `ar_src`=1. Go to EX_WR if `op_q`=STA, else EX_RD.
- EX_RD: `mem_rd`=1, `drload`=1. Go to EX_ALU.
- EX_ALU: `acload`=1; `alu_sel` = 00 for LDA, 01 for ADD, 10 for SUB, 11 for AND. Go to FETCH1.
- EX_WR: `mem_wr`=1. Go to FETCH1.
- HALT: `halted`=1, all strobes low; leave only on `rst` (`run` ignored).
- Outputs decode combinationally from `state`; in DECODE they also depend on `ir_op` and `zf`. `alu_sel` is 00 outside EX_ALU.
- `pcload` and `pcinc` are never high in the same cycle. `mem_rd` and `mem_wr` are never high in the same cycle.

## Timing
- Reset, at the first rising edge with `rst`=1: `state`=IDLE, `op_q`=0, `icount`=0. All strobes, `alu_sel` and `halted` are 0 in the following cycle.
- Reset mid-instruction aborts immediately, with no further strobes. It overrides `run` and HALT.
- Cycles per instruction, without wait states:
  - NOP, JMP, JZ, JNZ, CLA: 3.
  - STA: 5.
  - LDA, ADD, SUB, AND: 6.
  - First FETCH1 follows the cycle in IDLE in which `run`=1.
- `zf` is sampled only in the DECODE cycle; later changes in that instruction are ignored.
- `ir_op` must be valid in DECODE, i.e. one cycle after `irload`.

## Configuration
- `CTRL_MEM_WAIT_EN` defined:
  - FETCH2, EX_RD and EX_WR hold while `mem_ready`=0, keeping `mem_rd`/`mem_wr` asserted.
  - `irload`, `pcinc` and `drload` assert only in the cycle where `mem_ready`=1; the state advances on that edge.
  - `rst` still aborts a wait.
- Not defined: `mem_ready` is ignored and every memory access takes exactly one cycle.

## Test plan
- Reset then `run` pulse with IR=0x0000 (NOP): states 0->1->2->3->1; `pcinc` high exactly once; `icount`=1 after DECODE.
- IR=0x3012 (ADD 0x012): EX_ADDR has `arload`=1 and `ar_src`=1; EX_ALU has `acload`=1 and `alu_sel`=01; 6 cycles FETCH1 to FETCH1. Repeat with IR=0x2012 (STA): `mem_wr` high for one cycle, 5 cycles total.
- JZ with `zf`=1 then `zf`=0: `pcload`=1 in DECODE for the first, 0 for the second; `pcinc`=1 in FETCH2 for both.
- IR=0xF000: `halted`=1 and `state`=8 persist for 10 cycles with `run` toggling; `rst`=1 returns to IDLE with `icount`=0.
- Preload `icount`=0xFFFF via 65535 NOPs (or force): next DECODE gives 0x0000. Assert `rst` during EX_RD: next cycle `state`=0 and `mem_rd`=0.
- With CTRL_MEM_WAIT_EN, hold `mem_ready`=0 for 3 cycles in FETCH2: `mem_rd`=1 for 4 cycles; `irload`/`pcinc` only on the 4th; DECODE follows.
